i2c_byte_receiver: RTL and testbench
====================================

# i2c_byte_receiver

Clocked I2C target-side receiver that oversamples the raw `sda`/`scl` bus lines and detects START/STOP conditions. It shifts in the address byte and data bytes, drives ACK, and presents each received write byte with a one-cycle valid strobe. It is the downstream consumer of the bus-condition FSM in this codebase: it turns a recognised bus phase into byte-level data for the register/controller logic behind it.

## Interface
- `ADDR`, 7'h50, 7-bit target address this block responds to.
- `clk`  in  1  single system clock; all logic on rising edge; frequency ≥ 10× SCL.
- `reset`  in  1  synchronous, active-high reset.
- `sda`  in  1  raw bus data line, asynchronous to `clk`.
- `scl`  in  1  raw bus clock line, asynchronous to `clk`.
- `sda_oe`  out  1  1 = pull SDA low (ACK); 0 = release.
- `data_out`  out  8  last received data byte, MSB first on wire; held until next byte.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `addr_match`  out  1  high from a matching address byte until STOP/START/reset.
- `rw`  out  1  R/W bit of the matched address byte (1 = read).
- `busy`  out  1  high whenever state ≠ IDLE.
- `start_det`, `stop_det`  out  1 each  one-cycle pulses on START/STOP detection.

## Operation
- Input conditioning: `sda` and `scl` each pass through a 2-flop synchroniser (`sda_s`, `scl_s`), plus one previous-sample register each.
- Events, evaluated on synchronised samples:
  - scl_rise = prev 0, now 1; scl_fall = prev 1, now 0.
  - START = scl_s 1 and sda falls; STOP = scl_s 1 and sda rises.
- Priority per cycle: reset > START/STOP > scl edges. START and STOP cannot coincide.
- States:
  - IDLE: wait for START.
  - ADDR: receive address byte.
  - ADDR_ACK: drive ACK for address.
  - DATA: receive data byte.
  - DATA_ACK: drive ACK for data.
  - IGNORE: passive until STOP/START.
- START in any state (including repeated START): go to ADDR, bit count = 0, `sda_oe` = 0, `addr_match` = 0, `start_det` pulse.
- STOP in any state: go to IDLE, `sda_oe` = 0, `addr_match` = 0, `stop_det` pulse. A partial byte is discarded with no `data_valid`.
- ADDR/DATA shifting: on each scl_rise, shift `sda_s` into an 8-bit register, MSB first; 3-bit counter counts 0..7.
- ADDR, on 8th scl_rise:
  - shift[7:1] == ADDR: set `addr_match` = 1, `rw` = shift[0], go to ADDR_ACK.
  - Otherwise: go to IGNORE with `sda_oe` held 0.
- ACK phase (ADDR_ACK/DATA_ACK):
  - First scl_fall: `sda_oe` = 1.
  - Next scl_fall: `sda_oe` = 0, counter = 0.
  - Then ADDR_ACK with rw = 0 → DATA; ADDR_ACK with rw = 1 → IGNORE (reads unsupported, no NACK drive); DATA_ACK → DATA.
- DATA, on 8th scl_rise: `data_out` ← byte, `data_valid` pulse, go to DATA_ACK. Unlimited bytes per transaction.
- Counter wraps 7→0 only via the ACK phase. No overflow path exists.

## Timing
- Reset values: state IDLE, counter 0, shift 8'h00, `data_out` 8'h00; `sda_oe`, `data_valid`, `addr_match`, `rw`, `busy`, `start_det`, `stop_det` all 0. Synchroniser flops reset to 1 (idle bus).
- Pin-to-event latency: a pin change is detected on the 3rd `clk` edge after it (2 sync stages + edge compare). All outputs are registered and visible the cycle after detection.
- `data_valid` and `start_det`/`stop_det`: exactly 1 cycle wide.
- `sda_oe`: asserts 1 cycle after detected scl_fall following the 8th bit; deasserts 1 cycle after the next detected scl_fall.
- Reset mid-operation: returns to IDLE the next cycle, `sda_oe` released immediately, partial byte lost.

## Test plan
- START, address 0xA0 (0x50 write), then byte 0x3C, then STOP → `sda_oe` high for the 9th SCL of each byte; `addr_match`=1, `rw`=0; one `data_valid` pulse with `data_out`=0x3C; `stop_det` pulse; `busy` falls.
- START, address 0xA2 (0x51) + byte 0xFF → `sda_oe` never asserts, no `data_valid`, `addr_match`=0, state IGNORE until STOP.
- START, 0xA0, 4 data bits 1010, repeated START, 0xA0, byte 0x5A → no valid for the partial byte; a single `data_valid` with 0x5A; 2 `start_det` pulses.
- START, 0xA0, 5 bits, STOP → IDLE, no `data_valid`, `data_out` keeps its prior value.
- Assert `reset` for 1 cycle while `sda_oe`=1 during an ACK → `sda_oe`=0 the next cycle, all outputs at reset values, next START works normally.
- START, 0xA1 (read) → address ACK given, `rw`=1, then IGNORE: `sda_oe` stays 0 for 9 further SCL clocks.

Source files
------------

// File: rtl/i2c_byte_receiver.sv
// rtl/i2c_byte_receiver.sv - I2C target-side write receiver: oversampled START/STOP detect, address match, ACK drive, byte strobe
module i2c_byte_receiver #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sda,
    input  logic       scl,
    output logic       sda_oe,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       addr_match,
    output logic       rw,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic       sda_meta_q, sda_s_q, sda_prev_q;
    logic       scl_meta_q, scl_s_q, scl_prev_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       match_q, match_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    logic scl_rise, scl_fall, start_ev, stop_ev;

    assign scl_rise = scl_s_q & ~scl_prev_q;
    assign scl_fall = ~scl_s_q & scl_prev_q;
    assign start_ev = scl_s_q & ~sda_s_q & sda_prev_q;
    assign stop_ev  = scl_s_q & sda_s_q & ~sda_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_meta_q <= 1'b1;
            scl_s_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            sda_meta_q <= sda;
            sda_s_q    <= sda_meta_q;
            sda_prev_q <= sda_s_q;
            scl_meta_q <= scl;
            scl_s_q    <= scl_meta_q;
            scl_prev_q <= scl_s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // The ACK phase uses oe_q itself to tell the first scl_fall from the second.
    always_comb begin
        state_d = state_q;
        if (start_ev) begin
            state_d = S_ADDR;
        end else if (stop_ev) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:
                    if (scl_rise && cnt_q == 3'd7)
                        state_d = (shift_q[6:0] == ADDR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:
                    if (scl_fall && oe_q)
                        state_d = rw_q ? S_IGNORE : S_DATA;
                S_DATA:
                    if (scl_rise && cnt_q == 3'd7)
                        state_d = S_DATA_ACK;
                S_DATA_ACK:
                    if (scl_fall && oe_q)
                        state_d = S_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        match_d = match_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        if (start_ev) begin
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            match_d = 1'b0;
            start_d = 1'b1;
        end else if (stop_ev) begin
            oe_d    = 1'b0;
            match_d = 1'b0;
            stop_d  = 1'b1;
        end else begin
            case (state_q)
                S_ADDR, S_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s_q};
                        if (cnt_q != 3'd7) begin
                            cnt_d = cnt_q + 3'd1;
                        end else if (state_q == S_ADDR) begin
                            if (shift_q[6:0] == ADDR) begin
                                match_d = 1'b1;
                                rw_d    = sda_s_q;
                            end
                        end else begin
                            data_d  = {shift_q[6:0], sda_s_q};
                            valid_d = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 3'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    assign sda_oe     = oe_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign addr_match = match_q;
    assign rw         = rw_q;
    assign busy       = busy_q;
    assign start_det  = start_q;
    assign stop_det   = stop_q;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// tb/tb_i2c_byte_receiver.sv - directed bench for i2c_byte_receiver driving a bit-banged I2C master
module tb_i2c_byte_receiver;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sda = 1'b1;
    logic       scl = 1'b1;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid, addr_match, rw, busy, start_det, stop_det;

    int checks = 0;
    int errors = 0;
    int vcnt = 0, scnt = 0, pcnt = 0, longp = 0;
    logic dv_prev = 1'b0, st_prev = 1'b0, sp_prev = 1'b0;
    int v0, s0, p0;

    i2c_byte_receiver #(.ADDR(7'h50)) dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl),
        .sda_oe(sda_oe), .data_out(data_out), .data_valid(data_valid),
        .addr_match(addr_match), .rw(rw), .busy(busy),
        .start_det(start_det), .stop_det(stop_det)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) vcnt++;
        if (start_det)  scnt++;
        if (stop_det)   pcnt++;
        if ((data_valid && dv_prev) || (start_det && st_prev) || (stop_det && sp_prev)) longp++;
        dv_prev = data_valid;
        st_prev = start_det;
        sp_prev = stop_det;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda = b; wq(Q); scl = 1'b1; wq(2 * Q); scl = 1'b0; wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp, input string tag);
        for (int i = 7; i >= 0; i--) begin
            sda = b[i]; wq(Q); scl = 1'b1; wq(Q);
            chk("oe_during_bit", {7'd0, sda_oe}, 8'h00);
            wq(Q); scl = 1'b0; wq(Q);
        end
        sda = 1'b1; wq(Q); scl = 1'b1; wq(Q);
        chk(tag, {7'd0, sda_oe}, {7'd0, ack_exp});
        wq(Q); scl = 1'b0; wq(Q);
    endtask

    task automatic do_start();
        if (scl == 1'b0) begin
            sda = 1'b1; wq(Q); scl = 1'b1; wq(Q);
        end
        sda = 1'b0; wq(Q); scl = 1'b0; wq(Q);
    endtask

    task automatic do_stop();
        sda = 1'b0; wq(Q); scl = 1'b1; wq(Q); sda = 1'b1; wq(2 * Q);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_oe"},    {7'd0, sda_oe},     8'h00);
        chk({pfx, "_data"},  data_out,           8'h00);
        chk({pfx, "_valid"}, {7'd0, data_valid}, 8'h00);
        chk({pfx, "_match"}, {7'd0, addr_match}, 8'h00);
        chk({pfx, "_rw"},    {7'd0, rw},         8'h00);
        chk({pfx, "_busy"},  {7'd0, busy},       8'h00);
        chk({pfx, "_start"}, {7'd0, start_det},  8'h00);
        chk({pfx, "_stop"},  {7'd0, stop_det},   8'h00);
    endtask

    initial begin
        wq(5);
        reset = 1'b0;
        wq(1);
        chk_reset_outputs("rst");
        wq(5);

        // write 0x3C to 0x50
        v0 = vcnt; s0 = scnt; p0 = pcnt;
        do_start();
        chk("t1_start_cnt", 8'(scnt - s0), 8'd1);
        send_byte(8'hA0, 1'b1, "t1_addr_ack");
        chk("t1_match", {7'd0, addr_match}, 8'h01);
        chk("t1_rw", {7'd0, rw}, 8'h00);
        chk("t1_busy", {7'd0, busy}, 8'h01);
        send_byte(8'h3C, 1'b1, "t1_data_ack");
        chk("t1_valid_cnt", 8'(vcnt - v0), 8'd1);
        chk("t1_data", data_out, 8'h3C);
        do_stop();
        chk("t1_stop_cnt", 8'(pcnt - p0), 8'd1);
        chk("t1_busy_end", {7'd0, busy}, 8'h00);
        chk("t1_match_end", {7'd0, addr_match}, 8'h00);

        // wrong address 0x51
        v0 = vcnt;
        do_start();
        send_byte(8'hA2, 1'b0, "t2_addr_nack");
        send_byte(8'hFF, 1'b0, "t2_data_nack");
        chk("t2_match", {7'd0, addr_match}, 8'h00);
        chk("t2_busy", {7'd0, busy}, 8'h01);
        chk("t2_valid_cnt", 8'(vcnt - v0), 8'd0);
        do_stop();
        chk("t2_busy_end", {7'd0, busy}, 8'h00);

        // partial byte then repeated START
        v0 = vcnt; s0 = scnt;
        do_start();
        send_byte(8'hA0, 1'b1, "t3_addr_ack");
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("t3_partial_valid", 8'(vcnt - v0), 8'd0);
        do_start();
        chk("t3_match_cleared", {7'd0, addr_match}, 8'h00);
        send_byte(8'hA0, 1'b1, "t3_addr2_ack");
        send_byte(8'h5A, 1'b1, "t3_data_ack");
        do_stop();
        chk("t3_valid_cnt", 8'(vcnt - v0), 8'd1);
        chk("t3_data", data_out, 8'h5A);
        chk("t3_start_cnt", 8'(scnt - s0), 8'd2);

        // 5 bits then STOP
        v0 = vcnt;
        do_start();
        send_byte(8'hA0, 1'b1, "t4_addr_ack");
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        do_stop();
        chk("t4_valid_cnt", 8'(vcnt - v0), 8'd0);
        chk("t4_data_kept", data_out, 8'h5A);
        chk("t4_busy", {7'd0, busy}, 8'h00);

        // reset during address ACK
        do_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
        sda = 1'b1; wq(Q); scl = 1'b1; wq(Q);
        chk("t5_oe_before_reset", {7'd0, sda_oe}, 8'h01);
        reset = 1'b1; wq(1); reset = 1'b0;
        chk_reset_outputs("t5");
        wq(Q); scl = 1'b0; wq(Q);
        v0 = vcnt;
        do_start();
        send_byte(8'hA0, 1'b1, "t5_addr_ack");
        send_byte(8'h11, 1'b1, "t5_data_ack");
        chk("t5_valid_cnt", 8'(vcnt - v0), 8'd1);
        chk("t5_data", data_out, 8'h11);
        do_stop();

        // read request: ACKed, then ignored
        v0 = vcnt;
        do_start();
        send_byte(8'hA1, 1'b1, "t6_addr_ack");
        chk("t6_rw", {7'd0, rw}, 8'h01);
        chk("t6_match", {7'd0, addr_match}, 8'h01);
        send_byte(8'h00, 1'b0, "t6_no_ack");
        chk("t6_busy", {7'd0, busy}, 8'h01);
        do_stop();
        chk("t6_valid_cnt", 8'(vcnt - v0), 8'd0);
        chk("t6_rw_held", {7'd0, rw}, 8'h01);

        chk("pulse_width", 8'(longp), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
